// File: rtl/pipeline_control_pkg.sv
// Shared opcodes, FSM/forward encodings and shadow-entry types for pipeline_control.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipeline_control_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef enum logic [1:0] {
        PC_RUN   = 2'd0,
        PC_FLUSH = 2'd1,
        PC_DRAIN = 2'd2,
        PC_HALT  = 2'd3
    } pc_state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       is_load;
    } shadow_t;

    typedef struct packed {
        logic uses_rs1;
        logic uses_rs2;
        logic writes_rd;
        logic is_load;
    } op_use_t;

    // Non-writers are recorded with rd = 0, so the rs != 0 test also rejects them.
    function automatic logic [1:0] fwd_sel(
        input logic       used,
        input logic [4:0] rs,
        input logic       ex_vld,
        input logic [4:0] ex_rd,
        input logic       mem_vld,
        input logic [4:0] mem_rd
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (used && rs != 5'd0) begin
            if (ex_vld && ex_rd == rs)
                sel = FWD_EXMEM;
            else if (mem_vld && mem_rd == rs)
                sel = FWD_MEMWB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipeline_control_if.sv
// ID-stage observation and pipeline-control bundle between datapath and pipeline_control.
// Latency: n/a (wires only).
// Backpressure: stalls are expressed through pc_en/ifid_en/idex_bubble.
interface pipeline_control_if;

    logic       id_valid;
    logic [6:0] id_opcode;
    logic [4:0] id_addr1;
    logic [4:0] id_addr2;
    logic [4:0] id_addr_dest;
    logic       ex_redirect;
    logic       resume;

    logic       pc_en;
    logic       ifid_en;
    logic       ifid_flush;
    logic       idex_bubble;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       halted;

    modport master (
        output id_valid, id_opcode, id_addr1, id_addr2, id_addr_dest, ex_redirect, resume,
        input  pc_en, ifid_en, ifid_flush, idex_bubble, fwd_a, fwd_b, halted
    );

    modport slave (
        input  id_valid, id_opcode, id_addr1, id_addr2, id_addr_dest, ex_redirect, resume,
        output pc_en, ifid_en, ifid_flush, idex_bubble, fwd_a, fwd_b, halted
    );

endinterface

// File: rtl/pipeline_control_operand_use.sv
// Decodes an RV32I opcode into register-use flags {uses_rs1, uses_rs2, writes_rd, is_load}.
// Latency: combinational.
// Backpressure: none.
module pipeline_control_operand_use
    import pipeline_control_pkg::*;
(
    input  logic [6:0] opcode,
    output op_use_t    op_use
);

    always_comb begin
        op_use = '0;
        case (opcode)
            OP_JALR, OP_OP_IMM: begin
                op_use.uses_rs1  = 1'b1;
                op_use.writes_rd = 1'b1;
            end
            OP_LOAD: begin
                op_use.uses_rs1  = 1'b1;
                op_use.writes_rd = 1'b1;
                op_use.is_load   = 1'b1;
            end
            OP_STORE, OP_BRANCH: begin
                op_use.uses_rs1 = 1'b1;
                op_use.uses_rs2 = 1'b1;
            end
            OP_OP: begin
                op_use.uses_rs1  = 1'b1;
                op_use.uses_rs2  = 1'b1;
                op_use.writes_rd = 1'b1;
            end
            OP_LUI, OP_AUIPC, OP_JAL: begin
                op_use.writes_rd = 1'b1;
            end
            default: op_use = '0;
        endcase
    end

endmodule

// File: rtl/pipeline_control.sv
// Hazard/sequencing controller: stalls, bubbles, flushes, forwarding selects, SYSTEM drain-and-halt.
// Latency: enables/flush/bubble combinational; fwd_a/fwd_b/halted registered (1 cycle).
// Backpressure: load-use holds PC and IF/ID for one cycle; DRAIN/HALT hold them until resume.
module pipeline_control
    import pipeline_control_pkg::*;
(
    input  logic clk,
    input  logic rst,
    pipeline_control_if.slave bus
);

    pc_state_t  state, state_nxt;
    op_use_t    id_use;
    shadow_t    ex_q, ex_d;
    // Load status only matters while the producer sits in EX; WB only counts as occupancy.
    logic       mem_vld_q;
    logic [4:0] mem_rd_q;
    logic       wb_vld_q;

    logic       id_sys, load_use, drained, id_adv;
    logic       pc_en, ifid_en, ifid_flush, idex_bubble;
    logic [1:0] fwd_a_q, fwd_b_q;
    logic       halted_q;

    pipeline_control_operand_use u_operand_use (
        .opcode (bus.id_opcode),
        .op_use (id_use)
    );

    assign id_sys   = bus.id_valid && (bus.id_opcode == OP_SYSTEM);
    assign load_use = bus.id_valid && ex_q.valid && ex_q.is_load &&
                      ((id_use.uses_rs1 && bus.id_addr1 != 5'd0 && bus.id_addr1 == ex_q.rd) ||
                       (id_use.uses_rs2 && bus.id_addr2 != 5'd0 && bus.id_addr2 == ex_q.rd));
    assign drained  = !ex_q.valid && !mem_vld_q && !wb_vld_q;
    assign id_adv   = bus.id_valid && !idex_bubble;

    always_ff @(posedge clk) begin
        if (rst)
            state <= PC_RUN;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            PC_RUN: begin
                if (bus.ex_redirect)
                    state_nxt = PC_FLUSH;
                else if (id_sys)
                    state_nxt = PC_DRAIN;
            end
            PC_FLUSH: state_nxt = PC_RUN;
            PC_DRAIN: begin
                if (bus.ex_redirect)
                    state_nxt = PC_FLUSH;
                else if (drained)
                    state_nxt = PC_HALT;
            end
            PC_HALT: begin
                if (bus.resume)
                    state_nxt = PC_RUN;
            end
            default: state_nxt = PC_RUN;
        endcase
    end

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else begin
            case (state)
                PC_RUN: begin
                    if (bus.ex_redirect) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (id_sys || load_use) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_bubble = 1'b1;
                    end
                end
                PC_FLUSH: begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end
                PC_DRAIN: begin
                    idex_bubble = 1'b1;
                    if (bus.ex_redirect) begin
                        ifid_flush = 1'b1;
                    end else begin
                        pc_en   = 1'b0;
                        ifid_en = 1'b0;
                    end
                end
                PC_HALT: begin
                    // PC stays put on resume so the fetch behind SYSTEM is the next instruction.
                    pc_en       = 1'b0;
                    idex_bubble = 1'b1;
                    ifid_en     = bus.resume;
                    ifid_flush  = bus.resume;
                end
                default: begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_bubble = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        ex_d = '0;
        if (id_adv) begin
            ex_d.valid   = 1'b1;
            ex_d.rd      = id_use.writes_rd ? bus.id_addr_dest : 5'd0;
            ex_d.is_load = id_use.is_load;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q      <= '0;
            mem_vld_q <= 1'b0;
            mem_rd_q  <= 5'd0;
            wb_vld_q  <= 1'b0;
            fwd_a_q   <= FWD_RF;
            fwd_b_q   <= FWD_RF;
            halted_q  <= 1'b0;
        end else begin
            ex_q      <= ex_d;
            mem_vld_q <= ex_q.valid;
            mem_rd_q  <= ex_q.rd;
            wb_vld_q  <= mem_vld_q;
            fwd_a_q   <= id_adv ? fwd_sel(id_use.uses_rs1, bus.id_addr1, ex_q.valid, ex_q.rd,
                                          mem_vld_q, mem_rd_q) : FWD_RF;
            fwd_b_q   <= id_adv ? fwd_sel(id_use.uses_rs2, bus.id_addr2, ex_q.valid, ex_q.rd,
                                          mem_vld_q, mem_rd_q) : FWD_RF;
            halted_q  <= (state_nxt == PC_HALT);
        end
    end

    assign bus.pc_en       = pc_en;
    assign bus.ifid_en     = ifid_en;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_bubble = idex_bubble;
    assign bus.fwd_a       = fwd_a_q;
    assign bus.fwd_b       = fwd_b_q;
    assign bus.halted      = halted_q;

endmodule

// File: tb/tb_pipeline_control.sv
// Directed table-driven bench for pipeline_control plus hand-written reset sequences.
module tb_pipeline_control;

    localparam logic [6:0] LOAD = 7'b0000011;
    localparam logic [6:0] OPR  = 7'b0110011;
    localparam logic [6:0] OPI  = 7'b0010011;
    localparam logic [6:0] SYS  = 7'b1110011;

    typedef struct {
        logic       vld;
        logic [6:0] op;
        logic [4:0] a1;
        logic [4:0] a2;
        logic [4:0] rd;
        logic       redir;
        logic       res;
        logic [3:0] ctl;   // {pc_en, ifid_en, ifid_flush, idex_bubble}
        logic [1:0] fa;
        logic [1:0] fb;
        logic       h;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    vec_t vecs[$];

    pipeline_control_if bus();

    pipeline_control dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic vec_t v(input logic vld, input logic [6:0] op, input logic [4:0] a1,
                               input logic [4:0] a2, input logic [4:0] rd, input logic redir,
                               input logic res, input logic [3:0] ctl, input logic [1:0] fa,
                               input logic [1:0] fb, input logic h);
        vec_t r;
        r.vld = vld; r.op = op; r.a1 = a1; r.a2 = a2; r.rd = rd;
        r.redir = redir; r.res = res; r.ctl = ctl; r.fa = fa; r.fb = fb; r.h = h;
        return r;
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic [6:0] op, input logic [4:0] a1,
                         input logic [4:0] a2, input logic [4:0] rd, input logic redir,
                         input logic res);
        bus.id_valid     = vld;
        bus.id_opcode    = op;
        bus.id_addr1     = a1;
        bus.id_addr2     = a2;
        bus.id_addr_dest = rd;
        bus.ex_redirect  = redir;
        bus.resume       = res;
    endtask

    function automatic logic [3:0] ctl_now();
        return {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_bubble};
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;
        // Each row is one cycle; fa/fb/h are the registered values visible during that cycle.
        vecs.push_back(v(1, LOAD, 1,  0,  5,  0, 0, 4'b1100, 2'b00, 2'b00, 0)); // 0 LOAD x5
        vecs.push_back(v(1, OPR,  5,  6,  7,  0, 0, 4'b0001, 2'b00, 2'b00, 0)); // 1 load-use stall
        vecs.push_back(v(1, OPR,  5,  6,  7,  0, 0, 4'b1100, 2'b00, 2'b00, 0)); // 2 consumer advances
        vecs.push_back(v(1, OPI,  2,  0,  3,  0, 0, 4'b1100, 2'b10, 2'b00, 0)); // 3 fwd_a=10 from load
        vecs.push_back(v(1, OPR,  3,  3,  8,  0, 0, 4'b1100, 2'b00, 2'b00, 0)); // 4 back-to-back
        vecs.push_back(v(1, OPI,  0,  0,  4,  0, 0, 4'b1100, 2'b01, 2'b01, 0)); // 5
        vecs.push_back(v(1, OPR,  8,  8,  9,  0, 0, 4'b1100, 2'b00, 2'b00, 0)); // 6 one between
        vecs.push_back(v(1, OPI,  0,  0, 10,  0, 0, 4'b1100, 2'b10, 2'b10, 0)); // 7
        vecs.push_back(v(1, OPI, 10,  0, 11,  0, 0, 4'b1100, 2'b00, 2'b00, 0)); // 8
        vecs.push_back(v(1, OPR,  9,  9, 12,  0, 0, 4'b1100, 2'b01, 2'b00, 0)); // 9 two between
        vecs.push_back(v(1, LOAD, 1,  0,  0,  0, 0, 4'b1100, 2'b00, 2'b00, 0)); // 10 LOAD x0
        vecs.push_back(v(1, OPR,  0,  0, 13,  0, 0, 4'b1100, 2'b00, 2'b00, 0)); // 11 reads x0, no stall
        vecs.push_back(v(1, OPR, 13,  0,  0,  0, 0, 4'b1100, 2'b00, 2'b00, 0)); // 12 OP rd=x0
        vecs.push_back(v(1, OPR,  0,  0, 14,  0, 0, 4'b1100, 2'b01, 2'b00, 0)); // 13 reads x0
        vecs.push_back(v(1, OPR, 14,  0, 15,  1, 0, 4'b1111, 2'b00, 2'b00, 0)); // 14 redirect
        vecs.push_back(v(1, OPR, 14,  0, 15,  0, 0, 4'b1111, 2'b00, 2'b00, 0)); // 15 FLUSH
        vecs.push_back(v(1, OPR,  0,  0, 16,  0, 0, 4'b1100, 2'b00, 2'b00, 0)); // 16 RUN again
        vecs.push_back(v(1, LOAD, 0,  0,  5,  0, 0, 4'b1100, 2'b00, 2'b00, 0)); // 17
        vecs.push_back(v(1, OPR,  5,  0,  6,  1, 0, 4'b1111, 2'b00, 2'b00, 0)); // 18 redirect beats load-use
        vecs.push_back(v(0, OPI,  0,  0,  0,  0, 0, 4'b1111, 2'b00, 2'b00, 0)); // 19 FLUSH
        vecs.push_back(v(1, LOAD, 0,  0,  7,  0, 0, 4'b1100, 2'b00, 2'b00, 0)); // 20
        vecs.push_back(v(1, SYS,  0,  0,  0,  0, 0, 4'b0001, 2'b00, 2'b00, 0)); // 21 SYSTEM -> DRAIN
        vecs.push_back(v(1, SYS,  0,  0,  0,  0, 0, 4'b0001, 2'b00, 2'b00, 0)); // 22 DRAIN 1
        vecs.push_back(v(1, SYS,  0,  0,  0,  0, 0, 4'b0001, 2'b00, 2'b00, 0)); // 23 DRAIN 2
        vecs.push_back(v(1, SYS,  0,  0,  0,  0, 0, 4'b0001, 2'b00, 2'b00, 0)); // 24 DRAIN 3
        vecs.push_back(v(1, SYS,  0,  0,  0,  0, 0, 4'b0001, 2'b00, 2'b00, 1)); // 25 HALT
        vecs.push_back(v(1, SYS,  0,  0,  0,  0, 1, 4'b0111, 2'b00, 2'b00, 1)); // 26 resume
        vecs.push_back(v(1, OPR,  0,  0, 17,  0, 1, 4'b1100, 2'b00, 2'b00, 0)); // 27 stray resume
        vecs.push_back(v(1, SYS,  0,  0,  0,  0, 0, 4'b0001, 2'b00, 2'b00, 0)); // 28 SYSTEM -> DRAIN
        vecs.push_back(v(1, SYS,  0,  0,  0,  1, 0, 4'b1111, 2'b00, 2'b00, 0)); // 29 redirect in DRAIN
        vecs.push_back(v(0, OPI,  0,  0,  0,  0, 0, 4'b1111, 2'b00, 2'b00, 0)); // 30 FLUSH
        vecs.push_back(v(0, OPI,  0,  0,  0,  0, 0, 4'b1100, 2'b00, 2'b00, 0)); // 31 RUN

        rst = 1'b1;
        drive(0, OPI, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset.ctl",    ctl_now(),            4'b0011);
        check("reset.fwd_a",  {2'b00, bus.fwd_a},   4'b0000);
        check("reset.fwd_b",  {2'b00, bus.fwd_b},   4'b0000);
        check("reset.halted", {3'b000, bus.halted}, 4'b0000);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = 1'b0;
            drive(vecs[i].vld, vecs[i].op, vecs[i].a1, vecs[i].a2, vecs[i].rd,
                  vecs[i].redir, vecs[i].res);
            #1;
            check($sformatf("v%0d.ctl", i),    ctl_now(),            vecs[i].ctl);
            check($sformatf("v%0d.fwd_a", i),  {2'b00, bus.fwd_a},   {2'b00, vecs[i].fa});
            check($sformatf("v%0d.fwd_b", i),  {2'b00, bus.fwd_b},   {2'b00, vecs[i].fb});
            check($sformatf("v%0d.halted", i), {3'b000, bus.halted}, {3'b000, vecs[i].h});
        end

        // Reset while halted.
        begin
            int waited;
            waited = 0;
            @(negedge clk);
            drive(1, SYS, 0, 0, 0, 0, 0);
            #1;
            while (!bus.halted && waited < 10) begin
                @(negedge clk);
                #1;
                waited++;
            end
            check("halt_wait", {3'b000, bus.halted}, 4'b0001);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_halt.ctl", ctl_now(), 4'b0011);
        @(negedge clk);
        rst = 1'b0;
        drive(0, OPI, 0, 0, 0, 0, 0);
        #1;
        check("rst_halt.halted", {3'b000, bus.halted}, 4'b0000);
        check("rst_halt.run",    ctl_now(),            4'b1100);
        check("rst_halt.fwd",    {bus.fwd_a, bus.fwd_b}, 4'b0000);

        // Reset in the middle of a load-use stall: nothing may remain in flight.
        @(negedge clk);
        drive(1, LOAD, 0, 0, 5, 0, 0);
        @(negedge clk);
        drive(1, OPR, 5, 5, 6, 0, 0);
        rst = 1'b1;
        #1;
        check("rst_stall.ctl", ctl_now(), 4'b0011);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_stall.nostall", ctl_now(), 4'b1100);
        @(negedge clk);
        drive(0, OPI, 0, 0, 0, 0, 0);
        #1;
        check("rst_stall.fwd", {bus.fwd_a, bus.fwd_b}, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
